sr_func_calc: RTL and testbench
===============================

# sr_func_calc

Multi-cycle arithmetic coprocessor for the single-cycle RISC-V core. It computes y = a² + b³ for 8-bit unsigned operands and serves the custom HYP instruction. The CPU drives `a` from rs1 and `b` from the ALU B-operand (register or I-immediate), and asserts `start` while the instruction is in decode. It stalls the PC while `busy_o` is high and writes `y` (zero-extended to 32 bits) to rd once `busy_o` falls. Internally one shared 8-step shift-add multiplier performs all three products sequentially.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  system clock; everything updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  level request; sampled only in IDLE.
- `a`  in  8  operand a, unsigned.
- `b`  in  8  operand b, unsigned.
- `y`  out  24  result a² + b³; holds the last completed result.
- `busy_o`  out  1  high while a computation is in flight.
- `done_o`  out  1  one-cycle pulse in the cycle after completion; `y` is valid during it.

## Operation
- States: IDLE, MUL_BB, MUL_BBB, MUL_AA, ADD, DONE.
- IDLE:
  - `start`=1 at an edge: latch `a`, `b` into internal registers, clear the accumulator, go to MUL_BB.
  - Otherwise stay in IDLE.
- MUL_BB: 8 shift-add steps. Product b·b goes to a 16-bit temporary. Then go to MUL_BBB.
- MUL_BBB: 8 steps. Multiplicand is temp (16 bits), multiplier is b, result is 24 bits. Store b³ in the 24-bit accumulator. Then go to MUL_AA.
- MUL_AA: 8 steps computing a·a into the 16-bit temporary. Then go to ADD.
- Shift-add step: if the multiplier LSB = 1, add the multiplicand (shifted by the step index) into the partial product. The 3-bit step counter wraps 7→0 on phase exit.
- ADD: `y` <= accumulator + zero-extended temp. Go to DONE.
- DONE:
  - Lasts exactly one cycle; `start` is ignored during it.
  - Then go to IDLE unconditionally.
  - This holdoff stops the still-asserted `start` of the completing instruction from retriggering the block.
- Width rules:
  - b² ≤ 65025 fits 16 bits; b³ ≤ 16581375 fits 24 bits.
  - Maximum sum is 16646400 (0xFE0100) < 2²⁴, so no overflow or saturation logic is needed.
- `a`/`b` changes while not in IDLE are ignored; only the latched copies are used.
- `y` is not cleared on `start`; it changes only in ADD or on reset.

## Timing
- Reset: state=IDLE, `busy_o`=0, `done_o`=0, `y`=0. Step counter, temp, accumulator and latched operands are all 0.
- Reset has priority over every transition, including mid-computation. The in-flight result is discarded and `y` returns to 0.
- Edge E0 samples `start`=1 in IDLE:
  - `busy_o`=1 from E0.
  - MUL_BB occupies edges E1–E8, MUL_BBB E9–E16, MUL_AA E17–E24.
  - ADD executes at E25: `y` is updated, `busy_o`=0, `done_o`=1.
  - E26: `done_o`=0, state=IDLE.
- `busy_o` is high for exactly 25 cycles; latency from start edge to valid `y` is 25 cycles, independent of operand values.
- Earliest restart: `start` sampled at E27, so back-to-back operations have a 27-cycle period.
- `busy_o` and `done_o` are registered outputs with no combinational path from `start`.
- CPU contract:
  - The CPU writes rd and advances the PC at E26, the end of the DONE cycle.
  - A following HYP instruction presents `start` in the cycle after E26.

## Test plan
- Reset, then `a`=3, `b`=4, `start`=1 for one cycle. Required: `busy_o` high for 25 cycles, then `y`=73 (0x000049) with a one-cycle `done_o` pulse at the busy fall.
- `a`=255, `b`=255. Required: `y`=16646400 (0xFE0100) after 25 cycles with no overflow; `a`=0, `b`=0 gives `y`=0 with identical latency.
- `start` held high continuously with `a`=1, `b`=2. Required:
  - First result `y`=9.
  - DONE lasts one cycle, then IDLE.
  - Second op starts at E27 and again gives `y`=9.
  - `busy_o` low for exactly 2 cycles between operations.
- Start with `a`=2, `b`=3, then change to `a`=200, `b`=200 on the next cycle. Required: `y`=31 (latched operands used).
- Complete an op with `a`=3, `b`=4 (`y`=73), start a new op, then assert `rst` at cycle 10. Required:
  - Next edge: `busy_o`=0, `done_o`=0, `y`=0.
  - A subsequent `a`=5, `b`=1 op gives `y`=26 after 25 cycles.
- `start` asserted in the same cycle as `rst`. Required: ignored, block remains IDLE with `busy_o`=0.

Source files
------------

// File: rtl/sr_func_calc.sv
// sr_func_calc: multi-cycle coprocessor computing y = a*a + b*b*b for 8-bit unsigned operands.
// A single shift-add multiplier is time-shared across the three products:
// b*b, then (b*b)*b, then a*a. The final sum is formed in a one-cycle ADD state.
module sr_func_calc (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [23:0] y,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StMulBb,
    StMulBbb,
    StMulAa,
    StAdd,
    StDone
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [2:0]  r_cnt;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_temp;
  logic [23:0] r_acc;
  logic [23:0] r_prod;
  logic [23:0] r_y;
  logic        r_busy;
  logic        r_done;

  logic [23:0] w_mcand;
  logic [7:0]  w_mplier;
  logic [23:0] w_prod_next;
  logic        w_last;

  // Select multiplicand/multiplier for the current product phase.
  always_comb begin
    w_mcand  = 24'd0;
    w_mplier = 8'd0;
    unique case (r_state)
      StMulBb: begin
        w_mcand  = {16'd0, r_b};
        w_mplier = r_b;
      end
      StMulBbb: begin
        w_mcand  = {8'd0, r_temp};
        w_mplier = r_b;
      end
      StMulAa: begin
        w_mcand  = {16'd0, r_a};
        w_mplier = r_a;
      end
      default: begin
        w_mcand  = 24'd0;
        w_mplier = 8'd0;
      end
    endcase
  end

  // One shift-add step: add the multiplicand shifted by the step index when that multiplier bit is set.
  always_comb begin
    w_prod_next = r_prod + (w_mplier[r_cnt] ? (w_mcand << r_cnt) : 24'd0);
    w_last      = (r_cnt == 3'd7);
  end

  // Next-state logic; each multiply phase exits after its eighth step.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (start) w_state_next = StMulBb;
      StMulBb:  if (w_last) w_state_next = StMulBbb;
      StMulBbb: if (w_last) w_state_next = StMulAa;
      StMulAa:  if (w_last) w_state_next = StAdd;
      StAdd:    w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == StMulBb) || (w_state_next == StMulBbb) ||
                 (w_state_next == StMulAa) || (w_state_next == StAdd);
      r_done  <= (w_state_next == StDone);
    end
  end

  // Datapath: operand latch, shared multiplier accumulation, and final sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 3'd0;
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_temp <= 16'd0;
      r_acc  <= 24'd0;
      r_prod <= 24'd0;
      r_y    <= 24'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= 24'd0;
            r_prod <= 24'd0;
            r_cnt  <= 3'd0;
          end
        end
        StMulBb: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_temp <= w_prod_next[15:0];
            r_prod <= 24'd0;
          end else begin
            r_prod <= w_prod_next;
          end
        end
        StMulBbb: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_acc  <= w_prod_next;
            r_prod <= 24'd0;
          end else begin
            r_prod <= w_prod_next;
          end
        end
        StMulAa: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_temp <= w_prod_next[15:0];
            r_prod <= 24'd0;
          end else begin
            r_prod <= w_prod_next;
          end
        end
        StAdd: begin
          // Max sum 0xFE0100 fits 24 bits, so no overflow handling.
          r_y <= r_acc + {8'd0, r_temp};
        end
        default: begin
        end
      endcase
    end
  end

  assign y      = r_y;
  assign busy_o = r_busy;
  assign done_o = r_done;

endmodule

// File: tb/tb_sr_func_calc.sv
// Self-checking bench for sr_func_calc: directed cases plus random operands against a plain
// arithmetic reference (a*a + b*b*b).
module tb_sr_func_calc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [23:0] y;
  logic        busy_o;
  logic        done_o;

  int total;
  int bad;
  logic [23:0] prev_y;

  sr_func_calc dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .y      (y),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] ref_y(input logic [7:0] av, input logic [7:0] bv);
    int unsigned ai;
    int unsigned bi;
    int unsigned r;
    ai = av;
    bi = bv;
    r  = ai * ai + bi * bi * bi;
    return r[23:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands with start, return at the negedge after the sampling edge E0.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input bit hold);
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
    chk("y_held_on_start", {8'd0, y}, {8'd0, prev_y});
  endtask

  // Called at the negedge after E0; counts busy cycles, checks result and done pulse.
  task automatic finish(input logic [23:0] exp, input string tag);
    int n;
    n = 0;
    while (busy_o === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, n, 32'd25);
    chk({tag, "_done_pulse"}, {31'd0, done_o}, 32'd1);
    chk({tag, "_y"}, {8'd0, y}, {8'd0, exp});
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done_o}, 32'd0);
    chk({tag, "_busy_low"}, {31'd0, busy_o}, 32'd0);
    prev_y = exp;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    total  = 0;
    bad    = 0;
    prev_y = 24'd0;

    // Reset with start asserted at the same time: must be ignored.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'd9;
    b     = 8'd9;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_y", {8'd0, y}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {31'd0, busy_o}, 32'd0);

    // Basic operation and extremes.
    launch(8'd3, 8'd4, 1'b0);
    finish(24'd73, "op_3_4");
    launch(8'd255, 8'd255, 1'b0);
    finish(24'hFE0100, "op_max");
    launch(8'd0, 8'd0, 1'b0);
    finish(24'd0, "op_zero");

    // Start held high: DONE holdoff, then restart at E27 with 2 low busy cycles.
    launch(8'd1, 8'd2, 1'b1);
    finish(24'd9, "hold_first");
    @(negedge clk);
    chk("hold_restart_busy", {31'd0, busy_o}, 32'd1);
    start = 1'b0;
    finish(24'd9, "hold_second");

    // Operand change after the start edge is ignored.
    launch(8'd2, 8'd3, 1'b0);
    a = 8'd200;
    b = 8'd200;
    finish(24'd31, "latched_ops");

    // Reset mid-computation.
    launch(8'd3, 8'd4, 1'b0);
    finish(24'd73, "pre_rst");
    launch(8'd7, 8'd9, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_y", {8'd0, y}, 32'd0);
    rst    = 1'b0;
    prev_y = 24'd0;
    launch(8'd5, 8'd1, 1'b0);
    finish(24'd26, "post_rst");

    // Random operands, scrambling inputs during the computation.
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom_range(255, 0));
      rb = 8'($urandom_range(255, 0));
      launch(ra, rb, 1'b0);
      a = 8'($urandom);
      b = 8'($urandom);
      finish(ref_y(ra, rb), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
